ypbpr_to_rgb: RTL and testbench
===============================

Name: ypbpr_to_rgb

Overview:
- Pipelined colour-space decoder: converts 8-bit Y/Cb(Pb)/Cr(Pr) component video back to RGB.
- Inverse of the output-side RGB→YPbPr path, using the same channel pairing: G↔Y, B↔Pb, R↔Pr.
- Sits on the input side of the video chain, e.g. for component-captured or YUV-stored framebuffer sources, ahead of the scaler/VGA mux.
- Carries HS/VS/DE through with matched latency.

Parameters:
- OUT_W, 6, output bits per colour channel (1..8); the top OUT_W bits of the clamped 8-bit result are used.

Ports:
- clk  input  1  video clock
- reset_n  input  1  asynchronous active-low reset
- ce_pix  input  1  pixel clock enable; the pipeline advances only when 1
- conv_en  input  1  1 = convert, 0 = bypass
- full_range  input  1  1 = full-range BT.601 input (0..255), 0 = limited-range (Y 16..235, C 16..240)
- y_in  input  8  luma
- cb_in  input  8  blue-difference chroma, offset 128
- cr_in  input  8  red-difference chroma, offset 128
- hs_in, vs_in, de_in  input  1 each  sync and data enable aligned with pixel data
- r_out, g_out, b_out  output  OUT_W each  RGB result
- hs_out, vs_out, de_out  output  1 each  syncs delayed to match the RGB outputs

Behaviour:
- Reset (reset_n=0, asynchronous): all pipeline registers and all outputs clear to 0. The first valid output appears 3 ce_pix cycles after reset release.
- Pipeline: 3 stages; every register updates only on clk edges with ce_pix=1. With ce_pix=0, all stages and outputs hold.
- Latency is exactly 3 enabled cycles for data, syncs and bypass alike.
- Stage 1 registers:
  - yo = y_in − 16 (limited) or y_in (full), 9-bit signed.
  - cbo = cb_in − 128 and cro = cr_in − 128, 9-bit signed.
  - conv_en, full_range, the raw bypass bytes, and hs/vs/de.
  - Mode inputs are sampled here only, so a mode change takes effect on a pixel boundary.
- Stage 2: signed products in 20-bit signed, coefficients ×256.
  - Limited range: KY=298, KRV=409, KGU=100, KGV=208, KBU=516.
  - Full range: KY=256, KRV=359, KGU=88, KGV=183, KBU=454.
- Stage 3: sums, each plus 128 for rounding:
  - R = KY·yo + KRV·cro
  - G = KY·yo − KGU·cbo − KGV·cro
  - B = KY·yo + KBU·cbo
  - Clamp: if sum < 0 the result is 0; else if sum[19:8] > 255 the result is 255; else sum[15:8].
  - Output = result[7:8−OUT_W].
- Bypass (stage-1 conv_en=0): r=cr_in, g=y_in, b=cb_in, truncated to the top OUT_W bits. No offsets and no clamping; same 3-cycle latency.
- No out-of-range input is rejected. Limited-range inputs outside 16..235/240 are still computed and then clamped.
- de_in does not gate the data path; blanking pixels convert normally.
- Reset asserted mid-line clears everything immediately. Only pixels fed after release are output, with no stale data.

Test Plan (bench uses OUT_W=8 unless stated):
- Limited, conv_en=1, (Y,Cb,Cr)=(16,128,128) → RGB (0,0,0) after 3 ce. (235,128,128) → (255,255,255). With OUT_W=6 → (63,63,63).
- Full, (128,128,255) → R overflows and clamps to 255, G=37, B=128.
- Limited, (16,128,16) → R negative clamps to 0, G=91, B=0. Confirms low clamp and positive G path.
- ce_pix toggling 1-of-4 with an hs_in pulse on a marked pixel → outputs and hs_out change only on enabled edges. The marked pixel appears with its hs_out on the 3rd enabled edge; values hold while ce_pix=0.
- Bypass, conv_en=0, (y,cb,cr)=(34,56,12) → (r,g,b)=(12,34,56) after 3 ce. Toggle conv_en mid-stream → the switch lands on exactly the pixel sampled with the new mode.
- Assert reset_n=0 mid-line between clk edges → all outputs 0 without a clock edge. After release, the first 2 enabled cycles output 0 and the 3rd shows the first post-reset pixel.

Source files
------------

// File: rtl/ypbpr_to_rgb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ypbpr_to_rgb : 3-stage Y/Cb/Cr -> RGB decoder with matched sync delay     |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module ypbpr_to_rgb #(
  parameter int OUT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce_pix,
  input  logic             conv_en,
  input  logic             full_range,
  input  logic [7:0]       y_in,
  input  logic [7:0]       cb_in,
  input  logic [7:0]       cr_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             de_in,
  output logic [OUT_W-1:0] r_out,
  output logic [OUT_W-1:0] g_out,
  output logic [OUT_W-1:0] b_out,
  output logic             hs_out,
  output logic             vs_out,
  output logic             de_out
);

  // Coefficients scaled by 256; lr = limited range, fr = full range.
  localparam logic signed [19:0] c_ky_lr  = 20'sd298;
  localparam logic signed [19:0] c_krv_lr = 20'sd409;
  localparam logic signed [19:0] c_kgu_lr = 20'sd100;
  localparam logic signed [19:0] c_kgv_lr = 20'sd208;
  localparam logic signed [19:0] c_kbu_lr = 20'sd516;
  localparam logic signed [19:0] c_ky_fr  = 20'sd256;
  localparam logic signed [19:0] c_krv_fr = 20'sd359;
  localparam logic signed [19:0] c_kgu_fr = 20'sd88;
  localparam logic signed [19:0] c_kgv_fr = 20'sd183;
  localparam logic signed [19:0] c_kbu_fr = 20'sd454;
  localparam logic signed [19:0] c_round  = 20'sd128;

  // ---------------- stage 1: offset removal ----------------
  logic signed [8:0] w_y_off;
  logic signed [8:0] w_cb_off;
  logic signed [8:0] w_cr_off;

  assign w_y_off  = full_range ? {1'b0, y_in} : ({1'b0, y_in} - 9'd16);
  assign w_cb_off = {1'b0, cb_in} - 9'd128;
  assign w_cr_off = {1'b0, cr_in} - 9'd128;

  logic signed [8:0] r1_y;
  logic signed [8:0] r1_cb;
  logic signed [8:0] r1_cr;
  logic              r1_conv;
  logic              r1_full;
  logic [7:0]        r1_y_raw;
  logic [7:0]        r1_cb_raw;
  logic [7:0]        r1_cr_raw;
  logic              r1_hs;
  logic              r1_vs;
  logic              r1_de;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1_y      <= '0;
      r1_cb     <= '0;
      r1_cr     <= '0;
      r1_conv   <= 1'b0;
      r1_full   <= 1'b0;
      r1_y_raw  <= '0;
      r1_cb_raw <= '0;
      r1_cr_raw <= '0;
      r1_hs     <= 1'b0;
      r1_vs     <= 1'b0;
      r1_de     <= 1'b0;
    end else if (ce_pix) begin
      r1_y      <= w_y_off;
      r1_cb     <= w_cb_off;
      r1_cr     <= w_cr_off;
      r1_conv   <= conv_en;
      r1_full   <= full_range;
      r1_y_raw  <= y_in;
      r1_cb_raw <= cb_in;
      r1_cr_raw <= cr_in;
      r1_hs     <= hs_in;
      r1_vs     <= vs_in;
      r1_de     <= de_in;
    end
  end

  // ---------------- stage 2: products ----------------
  logic signed [19:0] w_ky;
  logic signed [19:0] w_krv;
  logic signed [19:0] w_kgu;
  logic signed [19:0] w_kgv;
  logic signed [19:0] w_kbu;
  logic signed [19:0] w_y_ext;
  logic signed [19:0] w_cb_ext;
  logic signed [19:0] w_cr_ext;

  assign w_ky  = r1_full ? c_ky_fr  : c_ky_lr;
  assign w_krv = r1_full ? c_krv_fr : c_krv_lr;
  assign w_kgu = r1_full ? c_kgu_fr : c_kgu_lr;
  assign w_kgv = r1_full ? c_kgv_fr : c_kgv_lr;
  assign w_kbu = r1_full ? c_kbu_fr : c_kbu_lr;

  assign w_y_ext  = {{11{r1_y[8]}},  r1_y};
  assign w_cb_ext = {{11{r1_cb[8]}}, r1_cb};
  assign w_cr_ext = {{11{r1_cr[8]}}, r1_cr};

  logic signed [19:0] r2_py;
  logic signed [19:0] r2_prv;
  logic signed [19:0] r2_pgu;
  logic signed [19:0] r2_pgv;
  logic signed [19:0] r2_pbu;
  logic               r2_conv;
  logic [7:0]         r2_y_raw;
  logic [7:0]         r2_cb_raw;
  logic [7:0]         r2_cr_raw;
  logic               r2_hs;
  logic               r2_vs;
  logic               r2_de;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r2_py     <= '0;
      r2_prv    <= '0;
      r2_pgu    <= '0;
      r2_pgv    <= '0;
      r2_pbu    <= '0;
      r2_conv   <= 1'b0;
      r2_y_raw  <= '0;
      r2_cb_raw <= '0;
      r2_cr_raw <= '0;
      r2_hs     <= 1'b0;
      r2_vs     <= 1'b0;
      r2_de     <= 1'b0;
    end else if (ce_pix) begin
      r2_py     <= w_ky  * w_y_ext;
      r2_prv    <= w_krv * w_cr_ext;
      r2_pgu    <= w_kgu * w_cb_ext;
      r2_pgv    <= w_kgv * w_cr_ext;
      r2_pbu    <= w_kbu * w_cb_ext;
      r2_conv   <= r1_conv;
      r2_y_raw  <= r1_y_raw;
      r2_cb_raw <= r1_cb_raw;
      r2_cr_raw <= r1_cr_raw;
      r2_hs     <= r1_hs;
      r2_vs     <= r1_vs;
      r2_de     <= r1_de;
    end
  end

  // ---------------- stage 3: sum, clamp, truncate ----------------
  function automatic logic [7:0] clamp_u8(input logic signed [19:0] s);
    logic [7:0] res;
    if (s[19])
      res = 8'd0;
    else if (s[19:8] > 12'd255)
      res = 8'd255;
    else
      res = s[15:8];
    return res;
  endfunction

  logic signed [19:0] w_sum_r;
  logic signed [19:0] w_sum_g;
  logic signed [19:0] w_sum_b;
  logic [7:0]         w_r8;
  logic [7:0]         w_g8;
  logic [7:0]         w_b8;

  assign w_sum_r = r2_py + r2_prv + c_round;
  assign w_sum_g = r2_py - r2_pgu - r2_pgv + c_round;
  assign w_sum_b = r2_py + r2_pbu + c_round;

  // Bypass keeps the G/Y, B/Cb, R/Cr pairing and skips offsets and clamping.
  assign w_r8 = r2_conv ? clamp_u8(w_sum_r) : r2_cr_raw;
  assign w_g8 = r2_conv ? clamp_u8(w_sum_g) : r2_y_raw;
  assign w_b8 = r2_conv ? clamp_u8(w_sum_b) : r2_cb_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      de_out <= 1'b0;
    end else if (ce_pix) begin
      r_out  <= w_r8[7 -: OUT_W];
      g_out  <= w_g8[7 -: OUT_W];
      b_out  <= w_b8[7 -: OUT_W];
      hs_out <= r2_hs;
      vs_out <= r2_vs;
      de_out <= r2_de;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ypbpr_to_rgb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ypbpr_to_rgb : directed vector bench for ypbpr_to_rgb                  |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_ypbpr_to_rgb;

  typedef struct {
    logic       conv;
    logic       full;
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic       hs;
    logic       vs;
    logic       de;
    logic [7:0] er;
    logic [7:0] eg;
    logic [7:0] eb;
  } vec_t;

  localparam int N = 12;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce_pix;
  logic       conv_en;
  logic       full_range;
  logic [7:0] y_in;
  logic [7:0] cb_in;
  logic [7:0] cr_in;
  logic       hs_in;
  logic       vs_in;
  logic       de_in;
  logic [7:0] r_out;
  logic [7:0] g_out;
  logic [7:0] b_out;
  logic       hs_out;
  logic       vs_out;
  logic       de_out;
  logic [5:0] r6;
  logic [5:0] g6;
  logic [5:0] b6;
  logic       hs6;
  logic       vs6;
  logic       de6;

  int checks = 0;
  int errors = 0;

  vec_t vecs [N];
  vec_t v;
  vec_t zero_px;
  vec_t mark_px;
  logic [7:0] exp_r  [4];
  logic       exp_hs [4];

  always #5 clk = ~clk;

  ypbpr_to_rgb #(.OUT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .conv_en(conv_en),
    .full_range(full_range), .y_in(y_in), .cb_in(cb_in), .cr_in(cr_in),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out)
  );

  ypbpr_to_rgb #(.OUT_W(6)) dut6 (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .conv_en(conv_en),
    .full_range(full_range), .y_in(y_in), .cb_in(cb_in), .cr_in(cr_in),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .r_out(r6), .g_out(g6), .b_out(b6),
    .hs_out(hs6), .vs_out(vs6), .de_out(de6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t d);
    conv_en    = d.conv;
    full_range = d.full;
    y_in       = d.y;
    cb_in      = d.cb;
    cr_in      = d.cr;
    hs_in      = d.hs;
    vs_in      = d.vs;
    de_in      = d.de;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " r"},  r_out, 8'd0);
    chk({tag, " g"},  g_out, 8'd0);
    chk({tag, " b"},  b_out, 8'd0);
    chk({tag, " syncs"}, {5'd0, hs_out, vs_out, de_out}, 8'd0);
  endtask

  task automatic chk_px(input string tag, input vec_t e);
    chk({tag, " r"}, r_out, e.er);
    chk({tag, " g"}, g_out, e.eg);
    chk({tag, " b"}, b_out, e.eb);
    chk({tag, " syncs"}, {5'd0, hs_out, vs_out, de_out}, {5'd0, e.hs, e.vs, e.de});
  endtask

  initial begin
    //           conv  full  y       cb      cr      hs    vs    de    R       G       B
    vecs[0]  = '{1'b1, 1'b0, 8'd16,  8'd128, 8'd128, 1'b0, 1'b0, 1'b1, 8'd0,   8'd0,   8'd0};
    vecs[1]  = '{1'b1, 1'b0, 8'd235, 8'd128, 8'd128, 1'b1, 1'b0, 1'b1, 8'd255, 8'd255, 8'd255};
    vecs[2]  = '{1'b1, 1'b1, 8'd128, 8'd128, 8'd255, 1'b0, 1'b1, 1'b1, 8'd255, 8'd37,  8'd128};
    vecs[3]  = '{1'b1, 1'b0, 8'd16,  8'd128, 8'd16,  1'b0, 1'b0, 1'b0, 8'd0,   8'd91,  8'd0};
    vecs[4]  = '{1'b1, 1'b0, 8'd128, 8'd128, 8'd128, 1'b1, 1'b1, 1'b0, 8'd130, 8'd130, 8'd130};
    vecs[5]  = '{1'b0, 1'b0, 8'd34,  8'd56,  8'd12,  1'b0, 1'b0, 1'b1, 8'd12,  8'd34,  8'd56};
    vecs[6]  = '{1'b1, 1'b0, 8'd128, 8'd128, 8'd128, 1'b0, 1'b1, 1'b0, 8'd130, 8'd130, 8'd130};
    vecs[7]  = '{1'b0, 1'b1, 8'd200, 8'd10,  8'd99,  1'b1, 1'b0, 1'b0, 8'd99,  8'd200, 8'd10};
    vecs[8]  = '{1'b1, 1'b1, 8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 8'd0,   8'd136, 8'd0};
    vecs[9]  = '{1'b1, 1'b1, 8'd255, 8'd255, 8'd255, 1'b1, 1'b1, 1'b1, 8'd255, 8'd121, 8'd255};
    vecs[10] = '{1'b1, 1'b0, 8'd81,  8'd90,  8'd240, 1'b0, 1'b1, 1'b1, 8'd255, 8'd0,   8'd0};
    vecs[11] = '{1'b1, 1'b0, 8'd100, 8'd150, 8'd100, 1'b1, 1'b0, 1'b1, 8'd53,  8'd112, 8'd142};

    zero_px = vecs[0];
    zero_px.hs = 1'b0;
    mark_px = vecs[1];
    mark_px.hs = 1'b1;
    exp_r[0] = 8'd0;   exp_hs[0] = 1'b0;
    exp_r[1] = 8'd0;   exp_hs[1] = 1'b0;
    exp_r[2] = 8'd255; exp_hs[2] = 1'b1;
    exp_r[3] = 8'd0;   exp_hs[3] = 1'b0;

    // Reset state, with garbage on the inputs and a clock edge under reset.
    reset_n = 1'b0;
    ce_pix  = 1'b1;
    drive(vecs[9]);
    #2;
    chk_all_zero("reset");
    tick();
    chk_all_zero("reset edge");
    #5;
    reset_n = 1'b1;

    // Streamed table: one pixel per enabled edge, result 3 edges later.
    for (int i = 0; i < N + 2; i++) begin
      if (i < N) drive(vecs[i]);
      tick();
      if (i >= 2) begin
        v = vecs[i-2];
        chk_px($sformatf("vec%0d", i - 2), v);
        chk($sformatf("vec%0d r6", i - 2), {2'd0, r6}, 8'(v.er >> 2));
        chk($sformatf("vec%0d g6", i - 2), {2'd0, g6}, 8'(v.eg >> 2));
        chk($sformatf("vec%0d b6", i - 2), {2'd0, b6}, 8'(v.eb >> 2));
      end
    end

    // Clock-enable 1-of-4 with a marked hs pixel.
    drive(zero_px);
    for (int i = 0; i < 3; i++) tick();
    chk("ce flush r", r_out, 8'd0);
    for (int k = 0; k < 4; k++) begin
      drive(k == 0 ? mark_px : zero_px);
      ce_pix = 1'b1;
      tick();
      ce_pix = 1'b0;
      chk($sformatf("ce en%0d r", k + 1), r_out, exp_r[k]);
      chk($sformatf("ce en%0d hs", k + 1), {7'd0, hs_out}, {7'd0, exp_hs[k]});
      for (int j = 0; j < 3; j++) begin
        conv_en    = 1'($urandom);
        full_range = 1'($urandom);
        y_in       = 8'($urandom);
        cb_in      = 8'($urandom);
        cr_in      = 8'($urandom);
        hs_in      = 1'b1;
        vs_in      = 1'b1;
        de_in      = 1'b1;
        tick();
        chk($sformatf("ce hold%0d.%0d r", k + 1, j), r_out, exp_r[k]);
        chk($sformatf("ce hold%0d.%0d hs", k + 1, j), {7'd0, hs_out}, {7'd0, exp_hs[k]});
      end
    end
    chk("ce hold 6b r", {2'd0, r6}, 8'd0);

    // Asynchronous reset mid-line, then the first post-reset pixels.
    ce_pix = 1'b1;
    drive(vecs[9]);
    for (int i = 0; i < 3; i++) tick();
    chk_px("pre-reset", vecs[9]);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    drive(vecs[9]);
    tick();
    chk_all_zero("post-reset 1");
    drive(vecs[4]);
    tick();
    chk_all_zero("post-reset 2");
    drive(vecs[5]);
    tick();
    chk_px("post-reset 3", vecs[9]);
    tick();
    chk_px("post-reset 4", vecs[4]);
    tick();
    chk_px("post-reset 5", vecs[5]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
